// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP/IPv4/Ethernet framing constants and state encoding
// Used by the transmit framer and the byte-level receiver.
package udp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK_SUM = 4'd1,
        ST_PREAMBLE  = 4'd2,
        ST_ETH_HEAD  = 4'd3,
        ST_IP_HEAD   = 4'd4,
        ST_UDP_HEAD  = 4'd5,
        ST_SEND_DATA = 4'd6,
        ST_CRC       = 4'd7,
        ST_IFG       = 4'd8
    } udp_state_t;

    localparam int CHECK_SUM_LEN = 4;
    localparam int PREAMBLE_LEN  = 8;
    localparam int ETH_HEAD_LEN  = 14;
    localparam int IP_HEAD_LEN   = 20;
    localparam int UDP_HEAD_LEN  = 8;
    localparam int CRC_LEN       = 4;
    localparam int MIN_PAYLOAD   = 18;
    localparam int MAX_PAYLOAD   = 1472;
    localparam int IFG_LEN       = 12;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    // Ones'-complement carry fold of a 32-bit partial sum.
    function automatic logic [31:0] csum_fold(input logic [31:0] s);
        return {16'd0, s[31:16]} + {16'd0, s[15:0]};
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-parallel Ethernet CRC-32 update register
// Ports: clk, rst_n (sync, active-low), clear (reload FFFFFFFF), en (fold data in),
//        data (byte, LSB first on the wire), crc (raw register, caller inverts for FCS).
module crc32_d8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // Reflected form: EDB88320 is 04C11DB7 bit-reversed, data shifted LSB first.
    always_comb begin
        crc_next = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320) : (crc_next >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            crc <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/udp_send.sv
// rtl/udp_send.sv - UDP/IPv4/Ethernet transmit framer, one byte per clock
// Ports: eth_txc clock, rst_n sync active-low reset; tx_start_en/tx_byte_num/des_mac/des_ip
//        start a frame; tx_req/tx_data fetch payload words from a read-latency-1 source;
//        tx_databyte/tx_databyte_en carry the framed byte stream; tx_busy, tx_done status.
// Build option: UDP_TX_CRC_EN appends the Ethernet FCS (via crc32_d8); otherwise the
//        frame ends at the last pad byte.
module udp_send
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC_ADDR = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP_ADDR  = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [15:0] BOARD_UDP_PORT = 16'd1234,
    parameter logic [15:0] DES_UDP_PORT   = 16'd1234,
    parameter logic [7:0]  IP_TTL         = 8'h40
) (
    input  logic        eth_txc,
    input  logic        rst_n,
    input  logic        tx_start_en,
    input  logic [15:0] tx_byte_num,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic [7:0]  tx_databyte,
    output logic        tx_databyte_en,
    output logic        tx_busy,
    output logic        tx_done
);

    udp_state_t  state, state_next;
    logic [15:0] cnt, cnt_next, last_idx;

    logic [15:0] byte_num, data_len, total_len, udp_len, ident, checksum;
    logic [47:0] des_mac_r;
    logic [31:0] des_ip_r;
    logic [31:0] sum, fold;

    logic        start_ok;
    logic [7:0]  byte_next;
    logic        en_next, req_next, done_next;

    logic [111:0] eth_hdr;
    logic [159:0] ip_hdr;
    logic [63:0]  udp_hdr;
    logic [7:0]   eth_b [ETH_HEAD_LEN];
    logic [7:0]   ip_b  [IP_HEAD_LEN];
    logic [7:0]   udp_b [UDP_HEAD_LEN];

    assign start_ok = tx_start_en && (tx_byte_num <= 16'(MAX_PAYLOAD));
    assign tx_busy  = (state != ST_IDLE);
    assign fold     = csum_fold(sum);

    assign eth_hdr = {des_mac_r, BOARD_MAC_ADDR, ETH_TYPE_IPV4};
    assign ip_hdr  = {8'h45, 8'h00, total_len, ident, 16'h4000, IP_TTL, IP_PROTO_UDP,
                      checksum, BOARD_IP_ADDR, des_ip_r};
    assign udp_hdr = {BOARD_UDP_PORT, DES_UDP_PORT, udp_len, 16'h0000};

    for (genvar i = 0; i < ETH_HEAD_LEN; i++) begin : g_eth
        assign eth_b[i] = eth_hdr[8*(ETH_HEAD_LEN-1-i) +: 8];
    end
    for (genvar i = 0; i < IP_HEAD_LEN; i++) begin : g_ip
        assign ip_b[i] = ip_hdr[8*(IP_HEAD_LEN-1-i) +: 8];
    end
    for (genvar i = 0; i < UDP_HEAD_LEN; i++) begin : g_udp
        assign udp_b[i] = udp_hdr[8*(UDP_HEAD_LEN-1-i) +: 8];
    end

`ifdef UDP_TX_CRC_EN
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        crc_en;

    // Covers destination MAC through the last pad byte; reloaded during preamble.
    assign crc_en = (state == ST_ETH_HEAD) || (state == ST_IP_HEAD) ||
                    (state == ST_UDP_HEAD) || (state == ST_SEND_DATA);
    assign fcs    = ~crc;

    crc32_d8 u_crc32_d8 (
        .clk   (eth_txc),
        .rst_n (rst_n),
        .clear (state == ST_PREAMBLE),
        .en    (crc_en),
        .data  (byte_next),
        .crc   (crc)
    );
`endif

    // Last cnt value of each phase; the IFG phase is one longer because its first
    // cycle still flushes the final byte through the output register.
    always_comb begin
        last_idx = 16'd0;
        case (state)
            ST_CHECK_SUM: last_idx = 16'(CHECK_SUM_LEN - 1);
            ST_PREAMBLE:  last_idx = 16'(PREAMBLE_LEN - 1);
            ST_ETH_HEAD:  last_idx = 16'(ETH_HEAD_LEN - 1);
            ST_IP_HEAD:   last_idx = 16'(IP_HEAD_LEN - 1);
            ST_UDP_HEAD:  last_idx = 16'(UDP_HEAD_LEN - 1);
            ST_SEND_DATA: last_idx = data_len - 16'd1;
`ifdef UDP_TX_CRC_EN
            ST_CRC:       last_idx = 16'(CRC_LEN - 1);
`endif
            ST_IFG:       last_idx = 16'(IFG_LEN);
            default:      last_idx = 16'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 16'd1;
        if (state == ST_IDLE) begin
            cnt_next = 16'd0;
            if (start_ok) state_next = ST_CHECK_SUM;
        end else if (cnt == last_idx) begin
            cnt_next = 16'd0;
            case (state)
                ST_CHECK_SUM: state_next = ST_PREAMBLE;
                ST_PREAMBLE:  state_next = ST_ETH_HEAD;
                ST_ETH_HEAD:  state_next = ST_IP_HEAD;
                ST_IP_HEAD:   state_next = ST_UDP_HEAD;
                ST_UDP_HEAD:  state_next = ST_SEND_DATA;
`ifdef UDP_TX_CRC_EN
                ST_SEND_DATA: state_next = ST_CRC;
                ST_CRC:       state_next = ST_IFG;
`else
                ST_SEND_DATA: state_next = ST_IFG;
`endif
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Byte for the next output cycle, plus request/done look-ahead.
    always_comb begin
        byte_next = 8'h00;
        en_next   = 1'b1;
        case (state)
            ST_PREAMBLE: byte_next = (cnt[2:0] == 3'd7) ? 8'hD5 : 8'h55;
            ST_ETH_HEAD: byte_next = eth_b[cnt[3:0]];
            ST_IP_HEAD:  byte_next = ip_b[cnt[4:0]];
            ST_UDP_HEAD: byte_next = udp_b[cnt[2:0]];
            ST_SEND_DATA: begin
                if (cnt < byte_num) begin
                    case (cnt[1:0])
                        2'd0:    byte_next = tx_data[31:24];
                        2'd1:    byte_next = tx_data[23:16];
                        2'd2:    byte_next = tx_data[15:8];
                        default: byte_next = tx_data[7:0];
                    endcase
                end
            end
`ifdef UDP_TX_CRC_EN
            ST_CRC: begin
                case (cnt[1:0])
                    2'd0:    byte_next = fcs[7:0];
                    2'd1:    byte_next = fcs[15:8];
                    2'd2:    byte_next = fcs[23:16];
                    default: byte_next = fcs[31:24];
                endcase
            end
`endif
            default: en_next = 1'b0;
        endcase

        // tx_req is registered, so it is decided three cycles before the word's
        // first byte is on the output: word 0 from UDP_HEAD, others mid-word.
        req_next = ((state == ST_UDP_HEAD) && (cnt == 16'(UDP_HEAD_LEN - 2)) &&
                    (byte_num != 16'd0)) ||
                   ((state == ST_SEND_DATA) && (cnt[1:0] == 2'd2) &&
                    ((cnt + 16'd2) < byte_num));
        done_next = (state == ST_IFG) && (cnt == 16'd0);
    end

    always_ff @(posedge eth_txc) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= 16'd0;
            byte_num       <= 16'd0;
            data_len       <= 16'd0;
            total_len      <= 16'd0;
            udp_len        <= 16'd0;
            des_mac_r      <= 48'd0;
            des_ip_r       <= 32'd0;
            ident          <= 16'd0;
            sum            <= 32'd0;
            checksum       <= 16'd0;
            tx_databyte    <= 8'd0;
            tx_databyte_en <= 1'b0;
            tx_req         <= 1'b0;
            tx_done        <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            tx_databyte    <= byte_next;
            tx_databyte_en <= en_next;
            tx_req         <= req_next;
            tx_done        <= done_next;

            if (tx_done) ident <= ident + 16'd1;

            if ((state == ST_IDLE) && start_ok) begin
                byte_num  <= tx_byte_num;
                data_len  <= (tx_byte_num < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : tx_byte_num;
                total_len <= tx_byte_num + 16'(IP_HEAD_LEN + UDP_HEAD_LEN);
                udp_len   <= tx_byte_num + 16'(UDP_HEAD_LEN);
                des_mac_r <= des_mac;
                des_ip_r  <= des_ip;
            end

            // Header checksum pipeline: two partial sums, two carry folds, invert.
            if (state == ST_CHECK_SUM) begin
                case (cnt[1:0])
                    2'd0: sum <= 32'h4500 + {16'd0, total_len} + {16'd0, ident} + 32'h4000 +
                                 {16'd0, IP_TTL, IP_PROTO_UDP};
                    2'd1: sum <= sum + {16'd0, BOARD_IP_ADDR[31:16]} + {16'd0, BOARD_IP_ADDR[15:0]} +
                                 {16'd0, des_ip_r[31:16]} + {16'd0, des_ip_r[15:0]};
                    2'd2: sum <= fold;
                    default: checksum <= ~fold[15:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_send.sv
// tb/tb_udp_send.sv - randomized self-checking bench for udp_send against a frame model
module tb_udp_send;

`ifdef UDP_TX_CRC_EN
    localparam int CRC_BYTES = 4;
`else
    localparam int CRC_BYTES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [31:0] tx_data;
    logic        tx_req;
    logic [7:0]  tx_databyte;
    logic        tx_databyte_en;
    logic        tx_busy;
    logic        tx_done;

    always #5 clk = ~clk;

    udp_send dut (
        .eth_txc        (clk),
        .rst_n          (rst_n),
        .tx_start_en    (tx_start_en),
        .tx_byte_num    (tx_byte_num),
        .des_mac        (des_mac),
        .des_ip         (des_ip),
        .tx_data        (tx_data),
        .tx_req         (tx_req),
        .tx_databyte    (tx_databyte),
        .tx_databyte_en (tx_databyte_en),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and passive monitor (samples on the falling edge).
    int         cyc = 0;
    logic [7:0] cap[$];
    int         cap_cyc[$];
    int         req_cyc[$];
    int         done_cnt = 0, done_cyc = 0, busy_fall_cyc = 0, busy_rises = 0;
    int         en_rises = 0, en_rise_cyc = 0, last_en_cyc = 0;
    logic       en_prev = 1'b0, busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_databyte_en) begin
            cap.push_back(tx_databyte);
            cap_cyc.push_back(cyc);
            last_en_cyc <= cyc;
            if (!en_prev) begin
                en_rises    <= en_rises + 1;
                en_rise_cyc <= cyc;
            end
        end
        if (tx_req) req_cyc.push_back(cyc);
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_busy && !busy_prev) busy_rises <= busy_rises + 1;
        if (!tx_busy && busy_prev) busy_fall_cyc <= cyc;
        en_prev   <= tx_databyte_en;
        busy_prev <= tx_busy;
    end

    // Read-latency-1 payload source: word appears the cycle after tx_req.
    logic [31:0] words [4096];
    int          rd_ptr = 0;

    always @(negedge clk) begin
        if (tx_req) begin
            @(posedge clk);
            #1;
            tx_data = words[rd_ptr % 4096];
            rd_ptr  = rd_ptr + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference frame built byte by byte from the framing rules.
    logic [7:0]  exp_q[$];
    logic [15:0] exp_ident = 16'd0;

    task automatic build_exp(input int n, input logic [47:0] mac, input logic [31:0] ip,
                             input logic [15:0] id, input int base);
        logic [47:0] bm;
        logic [31:0] bip;
        logic [7:0]  h [20];
        logic [15:0] tl, ul, ck;
        logic [31:0] w, crc;
        int          s, plen;
        bm  = 48'h00_11_22_33_44_55;
        bip = {8'd192, 8'd168, 8'd1, 8'd102};
        tl  = 16'(n + 28);
        ul  = 16'(n + 8);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(bm[47-8*i -: 8]);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        h[0] = 8'h45;     h[1] = 8'h00;     h[2] = tl[15:8];  h[3] = tl[7:0];
        h[4] = id[15:8];  h[5] = id[7:0];   h[6] = 8'h40;     h[7] = 8'h00;
        h[8] = 8'h40;     h[9] = 8'd17;     h[10] = 8'h00;    h[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[12+i] = bip[31-8*i -: 8];
            h[16+i] = ip[31-8*i -: 8];
        end
        s = 0;
        for (int k = 0; k < 10; k++) s += int'({h[2*k], h[2*k+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        ck = ~16'(s);
        h[10] = ck[15:8];
        h[11] = ck[7:0];
        for (int i = 0; i < 20; i++) exp_q.push_back(h[i]);
        exp_q.push_back(8'h04); exp_q.push_back(8'hD2);
        exp_q.push_back(8'h04); exp_q.push_back(8'hD2);
        exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        plen = (n < 18) ? 18 : n;
        for (int i = 0; i < plen; i++) begin
            if (i < n) begin
                w = words[(base + i / 4) % 4096];
                exp_q.push_back(w[31-8*(i%4) -: 8]);
            end else begin
                exp_q.push_back(8'h00);
            end
        end
        if (CRC_BYTES != 0) begin
            crc = 32'hFFFF_FFFF;
            for (int i = 8; i < exp_q.size(); i++) begin
                for (int b = 0; b < 8; b++) begin
                    if (crc[0] ^ exp_q[i][b]) crc = (crc >> 1) ^ 32'hEDB88320;
                    else crc = crc >> 1;
                end
            end
            crc = ~crc;
            for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
        end
    endtask

    task automatic pulse_start(input int n, input logic [47:0] mac, input logic [31:0] ip,
                               output int st);
        @(posedge clk);
        #1;
        tx_byte_num = 16'(n);
        des_mac     = mac;
        des_ip      = ip;
        tx_start_en = 1'b1;
        st          = cyc;
        @(posedge clk);
        #1;
        tx_start_en = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int n, input logic [47:0] mac,
                             input logic [31:0] ip, input bit use_fixed,
                             input logic [31:0] w0, input bit poke, output int cb);
        int base, rb, db, eb, st, st2, t, nw, bad, s;
        base = rd_ptr;
        nw   = (n + 3) / 4;
        for (int k = 0; k < nw; k++)
            words[(base + k) % 4096] = (k == 0 && use_fixed) ? w0 : $urandom;
        build_exp(n, mac, ip, exp_ident, base);
        cb = cap.size();
        rb = req_cyc.size();
        db = done_cnt;
        eb = en_rises;
        pulse_start(n, mac, ip, st);
        if (poke) begin
            t = 0;
            while (cyc < st + 50 && t < 100) begin @(posedge clk); #1; t++; end
            pulse_start(7, 48'hFFFF_FFFF_FFFF, 32'h0101_0101, st2);
        end
        t = 0;
        while (done_cnt == db && t < 4000) begin tick(); t++; end
        check({nm, "_done_cnt"}, 32'(done_cnt - db), 32'd1);
        if (poke) begin
            repeat (3) tick();
            pulse_start(7, 48'hFFFF_FFFF_FFFF, 32'h0101_0101, st2);
        end
        t = 0;
        while (tx_busy && t < 40) begin tick(); t++; end
        check({nm, "_len"}, 32'(cap.size() - cb), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (cb + i >= cap.size() || cap[cb+i] !== exp_q[i]) bad++;
        check({nm, "_bytes_bad"}, 32'(bad), 32'd0);
        check({nm, "_latency"}, 32'(en_rise_cyc - st), 32'd6);
        check({nm, "_en_gaps"}, 32'(en_rises - eb), 32'd1);
        check({nm, "_nreq"}, 32'(req_cyc.size() - rb), 32'(nw));
        bad = 0;
        for (int k = 0; k < nw && rb + k < req_cyc.size(); k++)
            if (cb + 50 + 4*k >= cap_cyc.size() || cap_cyc[cb+50+4*k] != req_cyc[rb+k] + 2) bad++;
        check({nm, "_req_timing"}, 32'(bad), 32'd0);
        check({nm, "_done_timing"}, 32'(done_cyc - last_en_cyc), 32'd1);
        check({nm, "_busy_fall"}, 32'(busy_fall_cyc - done_cyc), 32'd12);
        if (cap.size() >= cb + 42) begin
            s = 0;
            for (int k = 0; k < 10; k++) s += int'({cap[cb+22+2*k], cap[cb+23+2*k]});
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
            check({nm, "_csum_fold"}, 32'(s), 32'hFFFF);
        end
        if (poke) begin
            repeat (20) tick();
            check({nm, "_no_requeue"}, 32'(en_rises - eb), 32'd1);
            check({nm, "_idle_after"}, {31'd0, tx_busy}, 32'd0);
        end
        exp_ident = exp_ident + 16'd1;
    endtask

    initial begin
        int cb, st, br, be, n;
        logic [47:0] mac;
        rst_n       = 1'b0;
        tx_start_en = 1'b0;
        tx_byte_num = 16'd0;
        des_mac     = 48'd0;
        des_ip      = 32'd0;
        tx_data     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_databyte", {24'd0, tx_databyte}, 32'd0);
        check("rst_en", {31'd0, tx_databyte_en}, 32'd0);
        check("rst_req", {31'd0, tx_req}, 32'd0);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_frame("f4", 4, 48'hA1B2_C3D4_E5F6, {8'd192, 8'd168, 8'd1, 8'd10}, 1'b1,
                  32'h1122_3344, 1'b0, cb);
        check("f4_total_len", {16'd0, cap[cb+24], cap[cb+25]}, 32'h0020);
        check("f4_udp_len", {16'd0, cap[cb+46], cap[cb+47]}, 32'h000C);
        check("f4_payload", {cap[cb+50], cap[cb+51], cap[cb+52], cap[cb+53]}, 32'h1122_3344);

        run_frame("f5", 5, 48'h0200_0000_0001, $urandom, 1'b0, 32'd0, 1'b1, cb);
        run_frame("f0", 0, 48'h0200_0000_0002, $urandom, 1'b0, 32'd0, 1'b0, cb);

        br = busy_rises;
        be = en_rises;
        pulse_start(1473, 48'h0200_0000_0003, 32'h0A00_0001, st);
        repeat (20) tick();
        check("big_ignored_busy", 32'(busy_rises - br), 32'd0);
        check("big_ignored_en", 32'(en_rises - be), 32'd0);

        run_frame("f1472", 1472, 48'h0200_0000_0004, $urandom, 1'b0, 32'd0, 1'b0, cb);

        br = done_cnt;
        pulse_start(10, 48'h0200_0000_0005, 32'h0A00_0002, st);
        while (cyc < st + 16) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_en", {31'd0, tx_databyte_en}, 32'd0);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_byte", {24'd0, tx_databyte}, 32'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        check("midrst_no_done", 32'(done_cnt - br), 32'd0);
        exp_ident = 16'd0;

        run_frame("ffA", 9, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, cb);
        check("ffA_ident", {16'd0, cap[cb+26], cap[cb+27]}, 32'd0);
        run_frame("ffB", 23, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, cb);
        check("ffB_ident", {16'd0, cap[cb+26], cap[cb+27]}, 32'd1);

        for (int r = 0; r < 6; r++) begin
            n   = int'($urandom_range(0, 80));
            mac = {16'($urandom), $urandom};
            run_frame($sformatf("rnd%0d", r), n, mac, $urandom, 1'b0, 32'd0, 1'b0, cb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
